whack_round_controller: RTL and testbench
=========================================

Name: whack_round_controller

Overview:
- Game-sequencing FSM for the whack-a-mole top level.
- Decides when a new mole (digit on one of HEX0..HEX3) is spawned and advances the position/digit LFSRs.
- Times the player's reaction window, judges hits and misses, keeps score and lives, and shortens the window after every successful hit.
- Sits between the LFSR/hex-display datapath and the debounced, edge-detected button inputs.

Parameters:
- CNT_W, 27, width of the tick counter (must hold INIT_TICKS and GAP_TICKS).
- INIT_TICKS, 49_999_999, reaction window of the first round, in clock cycles minus 1.
- STEP_TICKS, 2_500_000, amount the window shrinks after each hit.
- MIN_TICKS, 9_999_999, floor of the reaction window.
- GAP_TICKS, 12_499_999, blank time between moles, in cycles minus 1.
- LIVES, 3, misses allowed per game (1..3).

Ports:
- clock, in, 1, system clock (CLOCK_50 at top).
- reset, in, 1, synchronous active-high reset.
- start, in, 1, one-cycle pulse; begins a game from IDLE or OVER.
- hit_strobe, in, 1, one-cycle pulse: a player button was pressed.
- hit_pos, in, 2, which display the pressed button targets; valid with hit_strobe.
- rand_pos, in, 2, current output of the position LFSR.
- rand_digit, in, 4, current output of the digit LFSR.
- lfsr_advance, out, 1, one-cycle pulse that steps both LFSRs.
- mole_valid, out, 1, a mole is currently shown.
- mole_pos, out, 2, display index of the current mole.
- mole_digit, out, 4, digit shown on the current mole.
- score, out, 8, hits this game; saturates at 255.
- lives, out, 2, lives remaining.
- game_over, out, 1, high while in OVER.
- window_ticks, out, CNT_W, current reaction-window reload value (for LEDR/debug).

Behaviour:
- Reset values: state IDLE; all outputs 0 except window_ticks=INIT_TICKS and lives=LIVES.
- Reset takes effect on the next clock edge from any state, including mid-round. Counter, score and mole registers are all cleared.
- Internal down-counter cnt is loaded and decremented by one every cycle. It "expires" on the cycle cnt==0.
- States:
  - IDLE: mole_valid=0. On start: score<=0, lives<=LIVES, window_ticks<=INIT_TICKS, cnt<=GAP_TICKS, go to GAP.
  - GAP: mole_valid=0; cnt decrements. On expiry go to SPAWN.
  - SPAWN (exactly 1 cycle):
    - latch mole_pos<=rand_pos and mole_digit<=rand_digit (values present this cycle);
    - assert lfsr_advance;
    - cnt<=window_ticks; go to WAIT.
    - mole_valid rises on the cycle after SPAWN.
  - WAIT: mole_valid=1; cnt decrements. Priority order, evaluated each cycle:
    1. hit_strobe && hit_pos==mole_pos: HIT. score<=sat(score+1); window_ticks<=max(window_ticks−STEP_TICKS, MIN_TICKS), computed without underflow; cnt<=GAP_TICKS; go to GAP.
    2. hit_strobe && hit_pos!=mole_pos: MISS.
    3. cnt expiry: MISS.
  - MISS handling (no extra state): lives<=lives−1. If lives was 1, go to OVER; otherwise cnt<=GAP_TICKS and go to GAP. window_ticks is unchanged on a miss.
  - OVER: game_over=1, mole_valid=0; score and lives held. On start, same action as from IDLE.
- A correct hit on the same cycle as expiry counts as a hit.
- hit_strobe is ignored outside WAIT, including during SPAWN.
- start is ignored in GAP, SPAWN and WAIT.
- Hit latency: hit_strobe at cycle N makes score/mole_valid change at edge N+1.
- Score saturates at 255 and does not wrap.
- mole_pos and mole_digit hold their last values after the mole clears.

Decomposition:
- Shared package (whack_pkg):
  - state encoding IDLE=0, GAP=1, SPAWN=2, WAIT=3, OVER=4 (3 bits);
  - default tick constants;
  - SCORE_W=8.
- One sub-module, tick_down_counter (load, load_value, enable, count, zero flag). Instantiated once and shared by GAP and WAIT.
- Score/window arithmetic stays inline.

Test Plan (INIT_TICKS=20, STEP_TICKS=4, MIN_TICKS=8, GAP_TICKS=3, LIVES=3):
- Reset then start → GAP for 4 cycles, SPAWN for 1 cycle with lfsr_advance=1, mole_pos/mole_digit equal the rand_* values sampled in SPAWN, mole_valid=1 on the next cycle.
- Correct hit 5 cycles into WAIT → score=1, window_ticks=16, mole_valid=0 next cycle. Repeat: window goes 12, 8, then stays 8 after the 4th and 5th hits.
- No press → mole clears 21 cycles after WAIT entry, lives 3→2, back to GAP. Wrong-position press → lives decrement on the next edge.
- Three misses → game_over=1, lives=0, score held. Hits are ignored in OVER. start → score=0, lives=3, window_ticks=20.
- Correct hit on the exact expiry cycle → counted as a hit, lives unchanged. Force score=255 and hit → score stays 255.
- Assert reset in the middle of WAIT → next cycle state IDLE, mole_valid=0, score=0, lives=3, no lfsr_advance.

Source files
------------

// File: rtl/whack_pkg.sv
// Shared types and default timing constants for the whack-a-mole round controller.
package whack_pkg;

  // Game sequencing states; encoding is visible on the debug state output.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GAP   = 3'd1,
    ST_SPAWN = 3'd2,
    ST_WAIT  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int unsigned DEF_CNT_W      = 27;
  localparam int unsigned DEF_INIT_TICKS = 49_999_999;
  localparam int unsigned DEF_STEP_TICKS = 2_500_000;
  localparam int unsigned DEF_MIN_TICKS  = 9_999_999;
  localparam int unsigned DEF_GAP_TICKS  = 12_499_999;
  localparam int unsigned DEF_LIVES      = 3;
  localparam int unsigned SCORE_W        = 8;

  // Saturating score increment: sticks at all-ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
    return (s == {SCORE_W{1'b1}}) ? s : s + {{(SCORE_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/tick_down_counter.sv
// Loadable down-counter shared by the gap and reaction-window phases.
module tick_down_counter #(
  parameter int unsigned W = 27
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // Load wins over decrement; the count parks at zero rather than wrapping.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/whack_round_controller.sv
// Round sequencing for whack-a-mole: spawns moles, times the reaction window,
// judges hits/misses and tracks score, lives and the shrinking window.
// Inputs start/hit_strobe are single-cycle pulses, no handshake back-pressure.
module whack_round_controller
  import whack_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned INIT_TICKS = DEF_INIT_TICKS,
  parameter int unsigned STEP_TICKS = DEF_STEP_TICKS,
  parameter int unsigned MIN_TICKS  = DEF_MIN_TICKS,
  parameter int unsigned GAP_TICKS  = DEF_GAP_TICKS,
  parameter int unsigned LIVES      = DEF_LIVES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             hit_strobe,
  input  logic [1:0]       hit_pos,
  input  logic [1:0]       rand_pos,
  input  logic [3:0]       rand_digit,
  output logic             lfsr_advance,
  output logic             mole_valid,
  output logic [1:0]       mole_pos,
  output logic [3:0]       mole_digit,
  output logic [7:0]       score,
  output logic [1:0]       lives,
  output logic             game_over,
  output logic [CNT_W-1:0] window_ticks,
  output logic [2:0]       state_dbg
);

  localparam logic [CNT_W-1:0] INIT_V = CNT_W'(INIT_TICKS);
  localparam logic [CNT_W-1:0] STEP_V = CNT_W'(STEP_TICKS);
  localparam logic [CNT_W-1:0] MIN_V  = CNT_W'(MIN_TICKS);
  localparam logic [CNT_W-1:0] GAP_V  = CNT_W'(GAP_TICKS);
  localparam logic [1:0]       LIVES_V = 2'(LIVES);
  // One bit wider so the "can we still shrink" test never overflows.
  localparam logic [CNT_W:0]   SHRINK_MIN = (CNT_W+1)'(MIN_TICKS) + (CNT_W+1)'(STEP_TICKS);

  state_t             state_d, state_q;
  logic [7:0]         score_d, score_q;
  logic [1:0]         lives_d, lives_q;
  logic [CNT_W-1:0]   window_d, window_q;
  logic [1:0]         mole_pos_d, mole_pos_q;
  logic [3:0]         mole_digit_d, mole_digit_q;
  logic               mole_valid_d, mole_valid_q;
  logic               lfsr_adv_d, lfsr_adv_q;
  logic               game_over_d, game_over_q;

  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_load_val;
  logic               cnt_en;
  logic [CNT_W-1:0]   cnt_value;
  logic               cnt_zero;

  tick_down_counter #(.W(CNT_W)) u_cnt (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_load_val),
    .enable     (cnt_en),
    .count      (cnt_value),
    .zero       (cnt_zero)
  );

  // Next-state and datapath decisions; flag outputs are derived from the next state
  // so they are registered and line up with the state they describe.
  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    lives_d      = lives_q;
    window_d     = window_q;
    mole_pos_d   = mole_pos_q;
    mole_digit_d = mole_digit_q;
    cnt_load     = 1'b0;
    cnt_load_val = GAP_V;
    cnt_en       = (state_q == ST_GAP) || (state_q == ST_WAIT);

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          score_d  = '0;
          lives_d  = LIVES_V;
          window_d = INIT_V;
          cnt_load = 1'b1;
          state_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_zero) state_d = ST_SPAWN;
      end
      ST_SPAWN: begin
        // LFSRs step on this same edge, so these are the pre-advance values.
        mole_pos_d   = rand_pos;
        mole_digit_d = rand_digit;
        cnt_load     = 1'b1;
        cnt_load_val = window_q;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        if (hit_strobe && (hit_pos == mole_pos_q)) begin
          score_d  = score_inc(score_q);
          window_d = ({1'b0, window_q} >= SHRINK_MIN) ? (window_q - STEP_V) : MIN_V;
          cnt_load = 1'b1;
          state_d  = ST_GAP;
        end else if (hit_strobe || cnt_zero) begin
          lives_d = lives_q - 2'd1;
          if (lives_q <= 2'd1) begin
            state_d = ST_OVER;
          end else begin
            cnt_load = 1'b1;
            state_d  = ST_GAP;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    mole_valid_d = (state_d == ST_WAIT);
    lfsr_adv_d   = (state_d == ST_SPAWN);
    game_over_d  = (state_d == ST_OVER);
  end

  // FSM and registered outputs, all cleared together by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      score_q      <= '0;
      lives_q      <= LIVES_V;
      window_q     <= INIT_V;
      mole_pos_q   <= '0;
      mole_digit_q <= '0;
      mole_valid_q <= 1'b0;
      lfsr_adv_q   <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      window_q     <= window_d;
      mole_pos_q   <= mole_pos_d;
      mole_digit_q <= mole_digit_d;
      mole_valid_q <= mole_valid_d;
      lfsr_adv_q   <= lfsr_adv_d;
      game_over_q  <= game_over_d;
    end
  end

  assign lfsr_advance = lfsr_adv_q;
  assign mole_valid   = mole_valid_q;
  assign mole_pos     = mole_pos_q;
  assign mole_digit   = mole_digit_q;
  assign score        = score_q;
  assign lives        = lives_q;
  assign game_over    = game_over_q;
  assign window_ticks = window_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_whack_round_controller.sv
// Bench for whack_round_controller with short tick constants.
module tb_whack_round_controller;

  localparam int CNT_W = 27;
  localparam int INIT  = 20;
  localparam int STEP  = 4;
  localparam int MINT  = 8;
  localparam int GAP   = 3;
  localparam int LIV   = 3;

  localparam int S_IDLE = 0, S_GAP = 1, S_SPAWN = 2, S_WAIT = 3, S_OVER = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             hit_strobe = 1'b0;
  logic [1:0]       hit_pos = '0;
  logic [1:0]       rand_pos = '0;
  logic [3:0]       rand_digit = '0;
  logic             lfsr_advance;
  logic             mole_valid;
  logic [1:0]       mole_pos;
  logic [3:0]       mole_digit;
  logic [7:0]       score;
  logic [1:0]       lives;
  logic             game_over;
  logic [CNT_W-1:0] window_ticks;
  logic [2:0]       state_dbg;

  whack_round_controller #(
    .CNT_W(CNT_W), .INIT_TICKS(INIT), .STEP_TICKS(STEP),
    .MIN_TICKS(MINT), .GAP_TICKS(GAP), .LIVES(LIV)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .hit_strobe(hit_strobe),
    .hit_pos(hit_pos), .rand_pos(rand_pos), .rand_digit(rand_digit),
    .lfsr_advance(lfsr_advance), .mole_valid(mole_valid), .mole_pos(mole_pos),
    .mole_digit(mole_digit), .score(score), .lives(lives), .game_over(game_over),
    .window_ticks(window_ticks), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard
  int total = 0;
  int bad   = 0;
  logic [5:0] exp_q[$];
  logic       prev_mv = 1'b0;
  logic [1:0] cur_pos = '0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One clock: sample just after the edge, then present fresh LFSR values.
  task automatic cyc();
    logic [5:0] e;
    @(posedge clock);
    #1;
    if (mole_valid && !prev_mv) begin
      if (exp_q.size() == 0) begin
        chk("mole_without_spawn", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("mole_pos", int'(mole_pos), int'(e[5:4]));
        chk("mole_digit", int'(mole_digit), int'(e[3:0]));
        cur_pos = e[5:4];
      end
    end
    prev_mv = mole_valid;
    rand_pos   = 2'($urandom_range(0, 3));
    rand_digit = 4'($urandom_range(0, 15));
    if (lfsr_advance) exp_q.push_back({rand_pos, rand_digit});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic pulse_hit(input logic [1:0] p);
    hit_strobe = 1'b1;
    hit_pos    = p;
    cyc();
    hit_strobe = 1'b0;
  endtask

  task automatic wait_mole();
    int n;
    n = 0;
    while (!mole_valid && n < 200) begin
      cyc();
      n++;
    end
    if (!mole_valid) chk("wait_mole_timeout", n, -1);
  endtask

  // Table of rounds: kind 0 = correct hit, 1 = wrong press, 2 = no press.
  typedef struct {
    int kind;
    int off;
    int e_clear;
    int e_score;
    int e_lives;
    int e_win;
    int e_state;
  } rec_t;

  rec_t tbl[9];

  // Model state for randomized play.
  int m_score, m_lives, m_win;

  initial begin
    int n;
    int kind, off;
    logic [1:0] p;

    tbl[0] = '{2, 0, 21, 0, 2, 20, S_GAP};
    tbl[1] = '{0, 5,  0, 1, 2, 16, S_GAP};
    tbl[2] = '{0, 0,  0, 2, 2, 12, S_GAP};
    tbl[3] = '{0, 3,  0, 3, 2,  8, S_GAP};
    tbl[4] = '{0, 7,  0, 4, 2,  8, S_GAP};
    tbl[5] = '{0, 2,  0, 5, 2,  8, S_GAP};
    tbl[6] = '{0, 8,  0, 6, 2,  8, S_GAP};
    tbl[7] = '{1, 4,  0, 6, 1,  8, S_GAP};
    tbl[8] = '{2, 0,  9, 6, 0,  8, S_OVER};

    // reset state
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    chk("rst_state", int'(state_dbg), S_IDLE);
    chk("rst_mole_valid", int'(mole_valid), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_lives", int'(lives), LIV);
    chk("rst_window", int'(window_ticks), INIT);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_lfsr_adv", int'(lfsr_advance), 0);

    // start -> 4 gap cycles -> 1 spawn cycle -> wait
    pulse_start();
    for (int i = 0; i < GAP + 1; i++) begin
      chk("gap_state", int'(state_dbg), S_GAP);
      chk("gap_no_adv", int'(lfsr_advance), 0);
      cyc();
    end
    chk("spawn_state", int'(state_dbg), S_SPAWN);
    chk("spawn_adv", int'(lfsr_advance), 1);
    chk("spawn_no_mole", int'(mole_valid), 0);
    // a press during SPAWN must be ignored
    pulse_hit(rand_pos);
    chk("wait_state", int'(state_dbg), S_WAIT);
    chk("wait_mole_valid", int'(mole_valid), 1);
    chk("wait_adv_low", int'(lfsr_advance), 0);
    chk("spawn_hit_ignored", int'(score), 0);

    // table-driven rounds
    for (int r = 0; r < 9; r++) begin
      wait_mole();
      if (tbl[r].kind == 2) begin
        n = 0;
        while (mole_valid && n < 100) begin
          cyc();
          n++;
        end
        chk($sformatf("t%0d_clear_cycles", r), n, tbl[r].e_clear);
      end else begin
        repeat (tbl[r].off) cyc();
        p = (tbl[r].kind == 0) ? cur_pos : cur_pos + 2'd1;
        pulse_hit(p);
      end
      chk($sformatf("t%0d_mole_valid", r), int'(mole_valid), 0);
      chk($sformatf("t%0d_score", r), int'(score), tbl[r].e_score);
      chk($sformatf("t%0d_lives", r), int'(lives), tbl[r].e_lives);
      chk($sformatf("t%0d_window", r), int'(window_ticks), tbl[r].e_win);
      chk($sformatf("t%0d_state", r), int'(state_dbg), tbl[r].e_state);
      chk($sformatf("t%0d_game_over", r), int'(game_over), (tbl[r].e_state == S_OVER) ? 1 : 0);
    end

    // presses ignored in OVER, then restart
    pulse_hit(cur_pos);
    cyc();
    chk("over_hit_score", int'(score), 6);
    chk("over_hit_lives", int'(lives), 0);
    chk("over_state", int'(state_dbg), S_OVER);
    chk("over_mole_valid", int'(mole_valid), 0);
    pulse_start();
    chk("restart_state", int'(state_dbg), S_GAP);
    chk("restart_score", int'(score), 0);
    chk("restart_lives", int'(lives), LIV);
    chk("restart_window", int'(window_ticks), INIT);
    chk("restart_game_over", int'(game_over), 0);

    // score saturation over 256 hits
    for (int i = 0; i < 256; i++) begin
      wait_mole();
      pulse_hit(cur_pos);
      if (i >= 253) chk($sformatf("sat_score_%0d", i), int'(score), (i + 1 > 255) ? 255 : i + 1);
    end
    chk("sat_window", int'(window_ticks), MINT);
    // press during GAP is ignored
    pulse_hit(cur_pos);
    chk("gap_hit_state", int'(state_dbg), S_GAP);
    chk("gap_hit_score", int'(score), 255);
    chk("gap_hit_lives", int'(lives), LIV);

    // start ignored in WAIT, then reset mid-round
    wait_mole();
    cyc();
    pulse_start();
    chk("wait_start_ignored", int'(state_dbg), S_WAIT);
    chk("wait_start_mv", int'(mole_valid), 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_q.delete();
    chk("midrst_state", int'(state_dbg), S_IDLE);
    chk("midrst_mole_valid", int'(mole_valid), 0);
    chk("midrst_score", int'(score), 0);
    chk("midrst_lives", int'(lives), LIV);
    chk("midrst_window", int'(window_ticks), INIT);
    chk("midrst_adv", int'(lfsr_advance), 0);

    // randomized play against the rule-level model
    pulse_start();
    m_score = 0;
    m_lives = LIV;
    m_win   = INIT;
    for (int r = 0; r < 60; r++) begin
      if (m_lives == 0) begin
        chk("rnd_game_over", int'(game_over), 1);
        pulse_start();
        m_score = 0;
        m_lives = LIV;
        m_win   = INIT;
      end
      wait_mole();
      kind = $urandom_range(0, 2);
      off  = $urandom_range(0, m_win);
      if (kind == 2) begin
        n = 0;
        while (mole_valid && n < 100) begin
          cyc();
          n++;
        end
        chk("rnd_clear_cycles", n, m_win + 1);
        m_lives--;
      end else begin
        repeat (off) cyc();
        p = (kind == 0) ? cur_pos : cur_pos + 2'($urandom_range(1, 3));
        pulse_hit(p);
        if (kind == 0) begin
          m_score = (m_score + 1 > 255) ? 255 : m_score + 1;
          m_win   = (m_win - STEP < MINT) ? MINT : m_win - STEP;
        end else begin
          m_lives--;
        end
      end
      chk("rnd_mole_valid", int'(mole_valid), 0);
      chk("rnd_score", int'(score), m_score);
      chk("rnd_lives", int'(lives), m_lives);
      chk("rnd_window", int'(window_ticks), m_win);
      chk("rnd_over_flag", int'(game_over), (m_lives == 0) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
